ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter sharing the single-port data RAM between the core's load/store port and a secondary loader port (program/debug loader). It sits between the core's RAM-side signals and the RAM macro. It has the following responsibilities:
- Sequence multi-cycle reads with a fixed RAM latency.
- Stall the single-cycle core while its access is pending.
- Return a one-cycle acknowledge to the loader.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 1, RAM read latency in cycles (legal 1..4); read data is valid LAT cycles after m_rd first rises

Ports:
- CLOCK  in  1  system clock, rising edge
- RST_n  in  1  reset, asynchronous, active-low
- c_rd  in  1  core load request (level, held while c_stall=1)
- c_wr  in  1  core store request (level)
- c_addr  in  AW  core byte address
- c_wdata  in  DW  core store data
- c_rdata  out  DW  core load data, valid in cycle c_stall falls after c_rd
- c_stall  out  1  freeze core (PC and register write) while 1
- l_req  in  1  loader request, held until l_ack
- l_we  in  1  loader write (1) / read (0), stable with l_req
- l_addr  in  AW  loader address
- l_wdata  in  DW  loader write data
- l_rdata  out  DW  loader read data, valid with l_ack
- l_ack  out  1  one-cycle completion pulse
- m_rd, m_wr  out  1  RAM read/write enables
- m_addr  out  AW  RAM address
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data

## Operation
- States:
  - IDLE: arbitrate.
  - RD: a read is in flight. Registered owner (CORE/LDR), address and down-counter cnt.
- Core request = c_rd | c_wr.
  - c_rd and c_wr together is illegal; c_wr wins.
- IDLE, granted write (core or loader):
  - m_wr=1, m_addr/m_wdata from the granted port, for one cycle.
  - Completes in the same cycle: core c_stall=0, or loader l_ack=1.
  - Stay in IDLE.
- IDLE, granted read:
  - m_rd=1, m_addr from the granted port.
  - Register owner and address; cnt=LAT-1.
  - Go to RD. Core c_stall=1.
- RD:
  - m_rd=1 and m_addr=registered address, every cycle.
  - When cnt≠0: decrement; core c_stall=1 if the core is requesting.
  - When cnt=0 (completion cycle): data on m_rdata.
    - Owner CORE: c_stall=0.
    - Owner LDR: l_ack=1.
    - Next state IDLE.
- Non-granted requester: the core sees c_stall=1; the loader sees l_ack=0. Its request stays pending.
- No arbitration takes place in RD; new requests wait for IDLE.
- c_rdata and l_rdata are both direct passthroughs of m_rdata. They are qualified by stall/ack only.
- When idle with no request: m_rd=m_wr=0, m_addr=0, m_wdata=0.
- Conflict in IDLE resolves to core priority (see Configuration).

## Timing
- Reset (RST_n=0, async):
  - State IDLE, owner CORE, cnt=0, last_grant=LDR.
  - m_rd=m_wr=0, m_addr=m_wdata=0, l_ack=0.
  - c_stall=0 while RST_n=0.
- Reset mid-read abandons the transaction; no ack is generated.
- Write latency: 0 wait states (completes in request cycle).
- Read latency: LAT+1 cycles of request (c_stall high for LAT cycles).
- Loader read occupancy is LAT+1 cycles, with l_ack in the last cycle.
- Back-to-back: the cycle after RD completion is IDLE and may grant immediately.
- Loader must deassert l_req, or present a new request, in the cycle after l_ack. A held request is treated as a new transaction.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: on simultaneous core/loader requests in IDLE, grant the port that did not receive the previous grant. last_grant is updated on every grant.
  - Undefined: fixed priority, core always wins. The loader may starve under continuous core traffic; last_grant logic is absent.

## Test plan
- LAT=2, core c_rd at addr 0x10, RAM holds 0xDEADBEEF -> m_rd high 3 cycles, c_stall=1,1,0, c_rdata=0xDEADBEEF in third cycle.
- Core c_wr addr 0x20 data 0x12345678, no loader -> m_wr=1 that cycle, c_stall=0, RAM[0x20]=0x12345678.
- Loader read in flight (LAT=2) when core c_wr arrives -> c_stall=1 until loader l_ack, then write issued next cycle with c_stall=0.
- Core and loader request simultaneously for 2 transactions each:
  - Fixed priority: order C,C,L,L.
  - With ARB_ROUND_ROBIN_EN: order C,L,C,L.
- Loader write 0xA5A5A5A5 at 0x40 -> l_ack=1 same cycle as m_wr; subsequent loader read returns 0xA5A5A5A5 with l_ack after LAT cycles.
- RST_n low mid-read at cnt=1 -> m_rd=0, c_stall=0, l_ack=0 immediately. After release, the FSM is in IDLE and grants the next request.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Signal bundle between the core/loader requesters, the arbiter and the RAM macro.
// slave is the arbiter's view; master is the requester-plus-RAM view.
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          c_rd;
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_stall;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] l_rdata;
  logic          l_ack;

  logic          m_rd;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_rd, c_wr, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    output c_rdata, c_stall, l_rdata, l_ack, m_rd, m_wr, m_addr, m_wdata
  );

  modport master (
    output c_rd, c_wr, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  c_rdata, c_stall, l_rdata, l_ack, m_rd, m_wr, m_addr, m_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Core/loader arbiter for the single-port data RAM with fixed read latency LAT.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on conflicts instead of core priority.
module ram_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic         CLOCK,
  input  logic         RST_n,
  ram_arbiter_if.slave bus,
  output logic         o_dbg_state
);

  typedef enum logic { S_IDLE = 1'b0, S_RD = 1'b1 } state_t;
  typedef enum logic { OWN_CORE = 1'b0, OWN_LDR = 1'b1 } owner_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t        r_state;
  owner_t        r_owner;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t        r_last_grant;
`endif

  logic          w_core_req;
  logic          w_grant_core;
  logic          w_grant_ldr;
  logic          w_grant_rd;
  logic          w_done;
  logic [DW-1:0] w_wdata;

  // Handshake: core holds c_rd/c_wr and is done in the cycle c_stall is 0;
  // loader holds l_req until the single-cycle l_ack. c_wr beats c_rd if both.
  assign w_core_req = bus.c_rd | bus.c_wr;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_core = w_core_req & (~bus.l_req | (r_last_grant == OWN_LDR));
`else
  assign w_grant_core = w_core_req;
`endif
  assign w_grant_ldr = bus.l_req & ~w_grant_core;
  assign w_grant_rd  = (w_grant_core & ~bus.c_wr) | (w_grant_ldr & ~bus.l_we);
  assign w_done      = (r_state == S_RD) && (r_cnt == 2'd0);
  assign w_wdata     = w_grant_core ? bus.c_wdata : bus.l_wdata;

  assign bus.c_rdata = bus.m_rdata;
  assign bus.l_rdata = bus.m_rdata;
  assign o_dbg_state = r_state;

  always_comb begin
    bus.m_rd    = 1'b0;
    bus.m_wr    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.c_stall = w_core_req;
    bus.l_ack   = 1'b0;
    if (r_state == S_RD) begin
      bus.m_rd   = 1'b1;
      bus.m_addr = r_addr;
      if (w_done) begin
        if (r_owner == OWN_CORE) bus.c_stall = 1'b0;
        else                     bus.l_ack   = 1'b1;
      end
    end else if (w_grant_core) begin
      bus.m_addr = bus.c_addr;
      if (bus.c_wr) begin
        bus.m_wr    = 1'b1;
        bus.m_wdata = w_wdata;
        bus.c_stall = 1'b0;
      end else begin
        bus.m_rd = 1'b1;
      end
    end else if (w_grant_ldr) begin
      bus.m_addr = bus.l_addr;
      if (bus.l_we) begin
        bus.m_wr    = 1'b1;
        bus.m_wdata = w_wdata;
        bus.l_ack   = 1'b1;
      end else begin
        bus.m_rd = 1'b1;
      end
    end
    // Outputs are forced quiet for the whole time reset is held.
    if (!RST_n) begin
      bus.m_rd    = 1'b0;
      bus.m_wr    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.c_stall = 1'b0;
      bus.l_ack   = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_CORE;
      r_addr       <= '0;
      r_cnt        <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= OWN_LDR;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
          if (w_grant_core)     r_last_grant <= OWN_CORE;
          else if (w_grant_ldr) r_last_grant <= OWN_LDR;
`endif
          if (w_grant_rd) begin
            r_state <= S_RD;
            r_owner <= w_grant_core ? OWN_CORE : OWN_LDR;
            r_addr  <= w_grant_core ? bus.c_addr : bus.l_addr;
            r_cnt   <= CNT_INIT;
          end
        end
        S_RD: begin
          if (r_cnt == 2'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter (LAT=2): directed scenarios with literal expectations, then
// random core/loader traffic compared every cycle against a transaction-level model.
module tb_ram_arbiter;
  localparam int LAT = 2;

  logic CLOCK;
  logic RST_n;
  logic dbg_state;

  ram_arbiter_if #(.AW(32), .DW(32)) bus ();

  ram_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .CLOCK       (CLOCK),
    .RST_n       (RST_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_rd = 1'b0; bus.c_wr = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
  endtask

  // RAM macro: data appears only in the LAT-th cycle after m_rd first rises.
  logic [31:0] ram [32];
  int          rd_run;
  logic        s_rd, s_wr;
  logic [31:0] s_addr, s_wd;

  assign bus.m_rdata = (bus.m_rd && rd_run == LAT) ? ram[bus.m_addr[6:2]] : 32'hBAD0_BAD0;

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = init_word(i);
    rd_run = 0; s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wd = '0;
    forever begin
      @(negedge CLOCK);
      s_rd = RST_n && bus.m_rd; s_wr = RST_n && bus.m_wr;
      s_addr = bus.m_addr; s_wd = bus.m_wdata;
      @(posedge CLOCK);
      if (!s_rd) rd_run = 0;
      else       rd_run = (rd_run >= LAT) ? 0 : rd_run + 1;
      if (s_wr) ram[s_addr[6:2]] = s_wd;
    end
  end

  // Reference model: one outstanding read recorded as (owner, address, completion cycle).
  logic [31:0] mm [32];
  bit          md_active;
  bit          md_owner_ldr;
  bit          md_last_ldr;
  logic [31:0] md_addr;
  int          md_done;
  int          cyc;

  task automatic model_step();
    bit creq, gc, gl, e_rd, e_wr, e_stall, e_ack, chk_wd;
    logic [31:0] e_addr, e_wd;
    creq = bus.c_rd | bus.c_wr;
    e_rd = 0; e_wr = 0; e_stall = 0; e_ack = 0; chk_wd = 1; e_addr = '0; e_wd = '0;
    if (!RST_n) begin
      md_active = 0;
      md_last_ldr = 1;
    end else if (md_active) begin
      e_rd = 1; e_addr = md_addr; chk_wd = 0; e_stall = creq;
      if (cyc == md_done) begin
        if (md_owner_ldr) begin
          e_ack = 1;
          chk("l_rdata", bus.l_rdata, mm[md_addr[6:2]]);
        end else begin
          e_stall = 0;
          chk("c_rdata", bus.c_rdata, mm[md_addr[6:2]]);
        end
        md_active = 0;
      end
    end else begin
      gc = creq; gl = bus.l_req && !creq;
`ifdef ARB_ROUND_ROBIN_EN
      if (creq && bus.l_req) begin gc = md_last_ldr; gl = !md_last_ldr; end
`endif
      e_stall = creq;
      if (gc) begin
        md_last_ldr = 0; e_addr = bus.c_addr;
        if (bus.c_wr) begin
          e_wr = 1; e_wd = bus.c_wdata; e_stall = 0; mm[bus.c_addr[6:2]] = bus.c_wdata;
        end else begin
          e_rd = 1; chk_wd = 0;
          md_active = 1; md_owner_ldr = 0; md_addr = bus.c_addr; md_done = cyc + LAT;
        end
      end else if (gl) begin
        md_last_ldr = 1; e_addr = bus.l_addr;
        if (bus.l_we) begin
          e_wr = 1; e_wd = bus.l_wdata; e_ack = 1; mm[bus.l_addr[6:2]] = bus.l_wdata;
        end else begin
          e_rd = 1; chk_wd = 0;
          md_active = 1; md_owner_ldr = 1; md_addr = bus.l_addr; md_done = cyc + LAT;
        end
      end
    end
    chk("m_rd", 32'(bus.m_rd), 32'(e_rd));
    chk("m_wr", 32'(bus.m_wr), 32'(e_wr));
    chk("m_addr", bus.m_addr, e_addr);
    if (chk_wd) chk("m_wdata", bus.m_wdata, e_wd);
    chk("c_stall", 32'(bus.c_stall), 32'(e_stall));
    chk("l_ack", 32'(bus.l_ack), 32'(e_ack));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mm[i] = init_word(i);
    md_active = 0; md_owner_ldr = 0; md_last_ldr = 1; md_addr = '0; md_done = 0; cyc = 0;
    forever begin
      @(negedge CLOCK);
      model_step();
      cyc++;
    end
  end

  // Stimulus
  logic [3:0] seq;
  int         n_c, n_l, k;
  bit         cd, ld, core_busy, ldr_busy, got;
  logic [3:0] exp_order;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b0011;
`endif
    RST_n = 1'b0;
    idle_inputs();
    bus.c_rd = 1'b1; bus.l_req = 1'b1;
    @(negedge CLOCK);
    chk("rst_c_stall", 32'(bus.c_stall), 32'd0);
    chk("rst_m_rd", 32'(bus.m_rd), 32'd0);
    chk("rst_l_ack", 32'(bus.l_ack), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    next_cycle();
    RST_n = 1'b1;
    idle_inputs();

    // Simultaneous core and loader writes, two each
    bus.c_wr = 1; bus.c_addr = 32'h00; bus.c_wdata = 32'h1111_0001;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h04; bus.l_wdata = 32'h2222_0001;
    seq = '0; n_c = 0; n_l = 0;
    for (int i = 0; i < 12 && (n_c < 2 || n_l < 2); i++) begin
      @(negedge CLOCK);
      cd = bus.c_wr && !bus.c_stall;
      ld = bus.l_ack;
      if (cd) begin seq = {seq[2:0], 1'b0}; n_c++; end
      if (ld) begin seq = {seq[2:0], 1'b1}; n_l++; end
      next_cycle();
      if (cd) begin
        if (n_c == 2) bus.c_wr = 0; else bus.c_wdata = 32'h1111_0002;
      end
      if (ld) begin
        if (n_l == 2) bus.l_req = 0; else bus.l_wdata = 32'h2222_0002;
      end
    end
    chk("arb_count", 32'(n_c + n_l), 32'd4);
    chk("arb_order", 32'(seq), 32'(exp_order));
    idle_inputs();

    // Core read at 0x10 (RAM holds DEADBEEF)
    bus.c_rd = 1; bus.c_addr = 32'h10;
    @(negedge CLOCK);
    chk("crd0_m_rd", 32'(bus.m_rd), 32'd1); chk("crd0_stall", 32'(bus.c_stall), 32'd1);
    next_cycle(); @(negedge CLOCK);
    chk("crd1_m_rd", 32'(bus.m_rd), 32'd1); chk("crd1_stall", 32'(bus.c_stall), 32'd1);
    next_cycle(); @(negedge CLOCK);
    chk("crd2_m_rd", 32'(bus.m_rd), 32'd1); chk("crd2_stall", 32'(bus.c_stall), 32'd0);
    chk("crd2_data", bus.c_rdata, 32'hDEAD_BEEF);
    next_cycle();
    idle_inputs();

    // Core write 0x20
    bus.c_wr = 1; bus.c_addr = 32'h20; bus.c_wdata = 32'h1234_5678;
    @(negedge CLOCK);
    chk("cwr_m_wr", 32'(bus.m_wr), 32'd1); chk("cwr_stall", 32'(bus.c_stall), 32'd0);
    next_cycle();
    idle_inputs();
    chk("cwr_ram", ram[8], 32'h1234_5678);

    // Loader write then read back at 0x40
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h40; bus.l_wdata = 32'hA5A5_A5A5;
    @(negedge CLOCK);
    chk("lwr_ack", 32'(bus.l_ack), 32'd1); chk("lwr_m_wr", 32'(bus.m_wr), 32'd1);
    next_cycle();
    bus.l_we = 0;
    @(negedge CLOCK); chk("lrd0_ack", 32'(bus.l_ack), 32'd0);
    next_cycle(); @(negedge CLOCK); chk("lrd1_ack", 32'(bus.l_ack), 32'd0);
    next_cycle(); @(negedge CLOCK); chk("lrd2_ack", 32'(bus.l_ack), 32'd1);
    chk("lrd2_data", bus.l_rdata, 32'hA5A5_A5A5);
    next_cycle();
    idle_inputs();

    // Core write arrives while a loader read is in flight
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h08;
    @(negedge CLOCK); chk("lfl0_ack", 32'(bus.l_ack), 32'd0);
    next_cycle();
    bus.c_wr = 1; bus.c_addr = 32'h0C; bus.c_wdata = 32'h0BAD_CAFE;
    @(negedge CLOCK);
    chk("lfl1_stall", 32'(bus.c_stall), 32'd1); chk("lfl1_m_wr", 32'(bus.m_wr), 32'd0);
    next_cycle(); @(negedge CLOCK);
    chk("lfl2_ack", 32'(bus.l_ack), 32'd1); chk("lfl2_stall", 32'(bus.c_stall), 32'd1);
    next_cycle();
    bus.l_req = 0;
    @(negedge CLOCK);
    chk("lfl3_m_wr", 32'(bus.m_wr), 32'd1); chk("lfl3_stall", 32'(bus.c_stall), 32'd0);
    chk("lfl3_addr", bus.m_addr, 32'h0C);
    next_cycle();
    idle_inputs();

    // Reset in the middle of a core read
    bus.c_rd = 1; bus.c_addr = 32'h10;
    @(negedge CLOCK); chk("rmr0_m_rd", 32'(bus.m_rd), 32'd1);
    next_cycle();
    RST_n = 0;
    @(negedge CLOCK);
    chk("rmr1_m_rd", 32'(bus.m_rd), 32'd0); chk("rmr1_stall", 32'(bus.c_stall), 32'd0);
    chk("rmr1_ack", 32'(bus.l_ack), 32'd0);
    next_cycle();
    RST_n = 1;
    @(negedge CLOCK);
    chk("rmr2_m_rd", 32'(bus.m_rd), 32'd1); chk("rmr2_stall", 32'(bus.c_stall), 32'd1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      next_cycle();
      @(negedge CLOCK);
      if (!bus.c_stall) got = 1;
    end
    chk("rmr_recover", 32'(got), 32'd1);
    next_cycle();
    idle_inputs();

    // Random traffic
    core_busy = 0; ldr_busy = 0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge CLOCK);
      cd = RST_n && (bus.c_rd || bus.c_wr) && !bus.c_stall;
      ld = RST_n && bus.l_ack;
      next_cycle();
      if (!RST_n) RST_n = 1;
      else if ($urandom_range(0, 399) == 0) RST_n = 0;
      if (!core_busy || cd) begin
        if ($urandom_range(0, 99) < 60) begin
          k = $urandom_range(0, 9);
          bus.c_rd = (k < 5) || (k == 9);
          bus.c_wr = (k >= 5);
          bus.c_addr = 32'($urandom_range(0, 31)) << 2;
          bus.c_wdata = $urandom;
          core_busy = 1;
        end else begin
          bus.c_rd = 0; bus.c_wr = 0; bus.c_addr = $urandom; core_busy = 0;
        end
      end
      if (!ldr_busy || ld) begin
        if ($urandom_range(0, 99) < 50) begin
          bus.l_req = 1;
          bus.l_we = 1'($urandom_range(0, 1));
          bus.l_addr = 32'($urandom_range(0, 31)) << 2;
          bus.l_wdata = $urandom;
          ldr_busy = 1;
        end else begin
          bus.l_req = 0; bus.l_addr = $urandom; ldr_busy = 0;
        end
      end
    end
    RST_n = 1;
    idle_inputs();
    repeat (4) next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
